// File: rtl/rx_block_sequence_checker.sv
// rx_block_sequence_checker
// Classifies received 64b/66b blocks (C/S/D/T/E), runs the receive state
// machine and forwards legal blocks one cycle later. Illegal blocks are
// replaced by EBLOCK. Saturating error and packet counters are also kept.
//
// state | meaning
// ------+---------------------------------------------------------
// INIT  | after reset, waiting for control or start block
// C     | idle / control blocks between packets
// D     | inside a packet, data blocks flowing
// T     | packet just terminated
// E     | last block was illegal in context, replaced by EBLOCK
module rx_block_sequence_checker #(
    parameter int NB_DATA        = 66,
    parameter int NB_ERR_COUNTER = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic                      i_valid,
    input  logic [NB_DATA-1:0]        i_data,
    output logic [NB_DATA-1:0]        o_data,
    output logic                      o_valid,
    output logic [2:0]                o_state,
    output logic                      o_err_block,
    output logic [NB_ERR_COUNTER-1:0] o_err_count,
    output logic [NB_ERR_COUNTER-1:0] o_pkt_count
);

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_C    = 3'd1,
        ST_D    = 3'd2,
        ST_T    = 3'd3,
        ST_E    = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        BLK_C,
        BLK_S,
        BLK_D,
        BLK_T,
        BLK_E
    } blk_t;

    localparam logic [NB_DATA-1:0] EBLOCK = {2'b10, 8'h1E, 56'hFE_FEFE_FEFE_FEFE};

    state_t                    state_q, state_d;
    logic [NB_DATA-1:0]        data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      err_block_q, err_block_d;
    logic [NB_ERR_COUNTER-1:0] err_count_q, err_count_d;
    logic [NB_ERR_COUNTER-1:0] pkt_count_q, pkt_count_d;

    blk_t   blk_class;
    state_t state_next;
    logic   accept;

    assign accept = i_enable && i_valid;

    // Classify the incoming block from its sync header and block type
    always_comb begin
        blk_class = BLK_E;
        if (i_data[65:64] == 2'b01) begin
            blk_class = BLK_D;
        end else if (i_data[65:64] == 2'b10) begin
            case (i_data[63:56])
                8'h1E, 8'h4B:                      blk_class = BLK_C;
                8'h78:                             blk_class = BLK_S;
                8'h87, 8'h99, 8'hAA, 8'hB4,
                8'hCC, 8'hD2, 8'hE1, 8'hFF:        blk_class = BLK_T;
                default:                           blk_class = BLK_E;
            endcase
        end
    end

    // Receive state transition for the current block, assuming it is accepted
    always_comb begin
        state_next = ST_E;
        case (state_q)
            ST_INIT, ST_C, ST_T: begin
                if (blk_class == BLK_C)      state_next = ST_C;
                else if (blk_class == BLK_S) state_next = ST_D;
                else                         state_next = ST_E;
            end
            ST_D: begin
                if (blk_class == BLK_D)      state_next = ST_D;
                else if (blk_class == BLK_T) state_next = ST_T;
                else                         state_next = ST_E;
            end
            ST_E: begin
                if (blk_class == BLK_C)      state_next = ST_C;
                else if (blk_class == BLK_D) state_next = ST_D;
                else if (blk_class == BLK_T) state_next = ST_T;
                else                         state_next = ST_E;
            end
            default: state_next = ST_E;
        endcase
    end

    // Register inputs: state, forwarded data, flags and saturating counters
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        valid_d     = accept;
        err_block_d = 1'b0;
        err_count_d = err_count_q;
        pkt_count_d = pkt_count_q;
        if (accept) begin
            state_d = state_next;
            if (state_next == ST_E) begin
                data_d      = EBLOCK;
                err_block_d = 1'b1;
                if (!(&err_count_q)) err_count_d = err_count_q + 1'b1;
            end else begin
                data_d = i_data;
            end
            if (state_q == ST_D && state_next == ST_T && !(&pkt_count_q)) begin
                pkt_count_d = pkt_count_q + 1'b1;
            end
        end
    end

    // Output and state registers with synchronous reset
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= ST_INIT;
            data_q      <= '0;
            valid_q     <= 1'b0;
            err_block_q <= 1'b0;
            err_count_q <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            err_block_q <= err_block_d;
            err_count_q <= err_count_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_state     = state_q;
    assign o_err_block = err_block_q;
    assign o_err_count = err_count_q;
    assign o_pkt_count = pkt_count_q;

endmodule

// File: tb/tb_rx_block_sequence_checker.sv
// Directed self-checking bench for rx_block_sequence_checker. A second
// instance with 4-bit counters exercises counter saturation.
module tb_rx_block_sequence_checker;

    localparam logic [65:0] EBLOCK = {2'b10, 8'h1E, 56'hFE_FEFE_FEFE_FEFE};
    localparam logic [65:0] BLK_C1 = {2'b10, 8'h1E, 56'h00_0000_0000_0001};
    localparam logic [65:0] BLK_C2 = {2'b10, 8'h4B, 56'h00_0000_0000_0002};
    localparam logic [65:0] BLK_C3 = {2'b10, 8'h1E, 56'h00_0000_0000_0003};
    localparam logic [65:0] BLK_S  = {2'b10, 8'h78, 56'h55_5555_5555_55D5};
    localparam logic [65:0] BLK_D1 = {2'b01, 64'h1111_2222_3333_4444};
    localparam logic [65:0] BLK_D2 = {2'b01, 64'h5555_6666_7777_8888};
    localparam logic [65:0] BLK_D3 = {2'b01, 64'h9999_AAAA_BBBB_CCCC};
    localparam logic [65:0] BLK_T  = {2'b10, 8'h87, 56'h00_0000_0000_0000};
    localparam logic [65:0] BLK_T2 = {2'b10, 8'hFF, 56'h12_3456_789A_BCDE};
    localparam logic [65:0] BLK_B11 = {2'b11, 64'hDEAD_BEEF_0000_0001};
    localparam logic [65:0] BLK_B00 = {2'b00, 64'h0123_4567_89AB_CDEF};

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_enable = 1'b1;
    logic        i_valid = 1'b0;
    logic [65:0] i_data = '0;

    logic [65:0] o_data;
    logic        o_valid;
    logic [2:0]  o_state;
    logic        o_err_block;
    logic [31:0] o_err_count;
    logic [31:0] o_pkt_count;

    logic [65:0] s_data;
    logic        s_valid;
    logic [2:0]  s_state;
    logic        s_err_block;
    logic [3:0]  s_err_count;
    logic [3:0]  s_pkt_count;

    int checks = 0;
    int errors = 0;

    always #5 i_clock = ~i_clock;

    rx_block_sequence_checker dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_enable   (i_enable),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_state    (o_state),
        .o_err_block(o_err_block),
        .o_err_count(o_err_count),
        .o_pkt_count(o_pkt_count)
    );

    rx_block_sequence_checker #(.NB_DATA(66), .NB_ERR_COUNTER(4)) dut_sat (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_enable   (i_enable),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_data     (s_data),
        .o_valid    (s_valid),
        .o_state    (s_state),
        .o_err_block(s_err_block),
        .o_err_count(s_err_count),
        .o_pkt_count(s_pkt_count)
    );

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // apply one cycle of stimulus, then settle just after the edge
    task automatic step(input logic rst, input logic en, input logic vld, input logic [65:0] d);
        i_reset  = rst;
        i_enable = en;
        i_valid  = vld;
        i_data   = d;
        @(posedge i_clock);
        #1;
    endtask

    // checks the main instance's per-cycle outputs
    task automatic chk_out(input string tag, input logic [2:0] st, input logic [65:0] d,
                           input logic vld, input logic eb);
        chk({tag, "_state"}, 66'(o_state), 66'(st));
        chk({tag, "_data"}, o_data, d);
        chk({tag, "_valid"}, 66'(o_valid), 66'(vld));
        chk({tag, "_errblk"}, 66'(o_err_block), 66'(eb));
    endtask

    logic [65:0] clean_in [8];
    logic [2:0]  clean_st [8];

    initial begin
        clean_in = '{BLK_C1, BLK_C2, BLK_S, BLK_D1, BLK_D2, BLK_D3, BLK_T, BLK_C3};
        clean_st = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd1};

        // reset state
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        chk_out("rst", 3'd0, '0, 1'b0, 1'b0);
        chk("rst_errcnt", 66'(o_err_count), 66'd0);
        chk("rst_pktcnt", 66'(o_pkt_count), 66'd0);

        // clean packet
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1, clean_in[i]);
            chk_out($sformatf("clean%0d", i), clean_st[i], clean_in[i], 1'b1, 1'b0);
        end
        chk("clean_errcnt", 66'(o_err_count), 66'd0);
        chk("clean_pktcnt", 66'(o_pkt_count), 66'd1);

        // illegal start
        step(1'b1, 1'b1, 1'b0, '0);
        chk("ill_rst_state", 66'(o_state), 66'd0);
        step(1'b0, 1'b1, 1'b1, BLK_D1);
        chk_out("ill_d", 3'd4, EBLOCK, 1'b1, 1'b1);
        chk("ill_errcnt", 66'(o_err_count), 66'd1);
        step(1'b0, 1'b1, 1'b1, BLK_C1);
        chk_out("ill_c", 3'd1, BLK_C1, 1'b1, 1'b0);
        chk("ill_errcnt2", 66'(o_err_count), 66'd1);

        // bad sync header mid-packet
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, BLK_S);
        chk_out("bad_s", 3'd2, BLK_S, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, BLK_D1);
        chk_out("bad_d1", 3'd2, BLK_D1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, BLK_B11);
        chk_out("bad_hdr", 3'd4, EBLOCK, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, BLK_D2);
        chk_out("bad_d2", 3'd2, BLK_D2, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, BLK_T2);
        chk_out("bad_t", 3'd3, BLK_T2, 1'b1, 1'b0);
        chk("bad_errcnt", 66'(o_err_count), 66'd1);
        chk("bad_pktcnt", 66'(o_pkt_count), 66'd1);

        // valid gaps, plus one cycle with enable low and valid high
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, BLK_S);
        chk_out("gap_s", 3'd2, BLK_S, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, BLK_B00);
            chk_out($sformatf("gap%0d", i), 3'd2, BLK_S, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1, BLK_B00);
        chk_out("gap_dis", 3'd2, BLK_S, 1'b0, 1'b0);
        chk("gap_dis_errcnt", 66'(o_err_count), 66'd0);
        step(1'b0, 1'b1, 1'b1, BLK_D3);
        chk_out("gap_d", 3'd2, BLK_D3, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, BLK_T);
        chk_out("gap_t", 3'd3, BLK_T, 1'b1, 1'b0);
        chk("gap_errcnt", 66'(o_err_count), 66'd0);
        chk("gap_pktcnt", 66'(o_pkt_count), 66'd1);

        // saturation on the 4-bit instance
        step(1'b1, 1'b1, 1'b0, '0);
        chk("sat_rst", 66'(s_err_count), 66'd0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b1, BLK_B00);
            chk($sformatf("sat_cnt%0d", i), 66'(s_err_count), 66'((i + 1 > 15) ? 15 : i + 1));
            chk($sformatf("sat_eb%0d", i), 66'(s_err_block), 66'd1);
        end
        chk("sat_state", 66'(s_state), 66'd4);
        chk("sat_wide_cnt", 66'(o_err_count), 66'd20);

        // reset mid-packet, reset coinciding with a valid block
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, BLK_S);
        step(1'b0, 1'b1, 1'b1, BLK_D1);
        chk("mid_pre_state", 66'(o_state), 66'd2);
        step(1'b1, 1'b1, 1'b1, BLK_D2);
        chk_out("mid_rst", 3'd0, '0, 1'b0, 1'b0);
        chk("mid_rst_errcnt", 66'(o_err_count), 66'd0);
        chk("mid_rst_pktcnt", 66'(o_pkt_count), 66'd0);
        step(1'b0, 1'b1, 1'b1, BLK_T);
        chk_out("mid_t", 3'd4, EBLOCK, 1'b1, 1'b1);
        chk("mid_errcnt", 66'(o_err_count), 66'd1);
        chk("mid_pktcnt", 66'(o_pkt_count), 66'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // guard against a hung run
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rx_block_sequence_checker.md
# rx_block_sequence_checker

Receive-side 64b/66b block sequence checker for the 100GbE PCS decoder path. It consumes one 66-bit block per valid cycle, classifies it (C/S/D/T/E) and runs the receive state machine (INIT, C, D, T, E). Legal blocks are forwarded after one register stage; illegal blocks are replaced by the error block. Error and packet counts are kept for link-quality monitoring. It sits directly downstream of the RX frame/test-block source and upstream of the 66b-to-MII decode.

## Interface
- NB_DATA, 66, block width (sync header in [65:64], block type in [63:56])
- NB_ERR_COUNTER, 32, width of error and packet counters (saturating)
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  global enable; low freezes all state and forces o_valid=0
- i_valid  in  1  i_data carries a block this cycle
- i_data  in  NB_DATA  received 66-bit block
- o_data  out  NB_DATA  forwarded block, or EBLOCK
- o_valid  out  1  o_data valid
- o_state  out  3  current FSM state: INIT=0, C=1, D=2, T=3, E=4
- o_err_block  out  1  pulse: the block on o_data was replaced by EBLOCK
- o_err_count  out  NB_ERR_COUNTER  blocks replaced since reset
- o_pkt_count  out  NB_ERR_COUNTER  D→T transitions since reset

## Operation
- A block is accepted only when i_enable && i_valid. Otherwise FSM, counters and o_data hold.
- Classification is combinational on i_data:
  - sync 2'b01 → D.
  - sync 2'b10 with type 0x1E or 0x4B → C.
  - sync 2'b10 with type 0x78 → S.
  - sync 2'b10 with type in {0x87,0x99,0xAA,0xB4,0xCC,0xD2,0xE1,0xFF} → T.
  - Any other type, or sync 2'b00/2'b11 → E.
- Next-state rules on an accepted block:
  - INIT: C→C, S→D, else →E.
  - C: C→C, S→D, else →E.
  - D: D→D, T→T, else →E.
  - T: C→C, S→D, else →E.
  - E: C→C, D→D, T→T, S or E→E.
- Data substitution:
  - Next state ≠ E: o_data = i_data.
  - Next state = E: o_data = EBLOCK = {2'b10, 8'h1E, 56'hFEFE_FEFE_FEFE_FE}, o_err_block=1, and o_err_count increments.
- o_pkt_count increments only on a D→T transition.
- Both counters saturate at all-ones.
- Reset values: o_state=INIT, o_data=0, o_valid=0, o_err_block=0, both counters 0.
- Reset has priority over any simultaneous valid block and aborts an in-flight packet. The FSM returns to INIT and the counters clear.

## Timing
- Latency is 1 cycle: a block accepted at edge N appears on o_data/o_valid/o_err_block after edge N, together with the updated o_state and counters.
- o_valid = registered (i_enable && i_valid). It deasserts the cycle after a gap. o_data holds its last value during gaps.
- o_err_block is registered and valid only while o_valid=1. It is 0 on gap cycles.
- No back-pressure: the block accepts a block every cycle.
- A counter at saturation stays at all-ones. Its increment condition is ignored, with no wrap.
- Reset asserted for one cycle is sufficient. The first valid block after deassertion is classified from INIT.

## Test plan
- **Clean packet:** reset, then C,C,S,D,D,D,T,C.
  - Required: o_state 1,1,2,2,2,2,3,1.
  - Required: o_data equals the inputs delayed by 1 cycle; o_err_count=0; o_pkt_count=1.
- **Illegal start:** D immediately after reset.
  - Required: o_state=4, o_data=EBLOCK, o_err_block=1, o_err_count=1.
  - Follow-up: then C → o_state=1, o_err_block=0.
- **Bad sync header mid-packet:** S, D, {2'b11,…}, D, T.
  - Required: o_state 2,2,4,2,3.
  - Required: third output is EBLOCK; o_err_count=1; o_pkt_count=1.
- **Valid gaps:** S, gap×3, D, T, with i_valid=0 during the gaps.
  - Required: state and o_data hold through the gaps; o_valid=0 for 3 cycles.
  - Required: no errors; o_pkt_count=1.
- **Saturation:** NB_ERR_COUNTER=4; 20 consecutive blocks with sync 2'b00.
  - Required: o_err_count reaches 15 and stays 15; o_err_block=1 on every valid cycle.
- **Reset mid-packet:** S, D, reset, T.
  - Required: after reset o_state=0 and counters=0.
  - Required: T from INIT → o_state=4, o_err_count=1, o_pkt_count=0.
